data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the MEM-stage data-memory interface: accepts one load or store request at a time from the MEM stage, applies configurable wait states, and commits stores with byte-lane enables. It returns sign- or zero-extended load data with a one-cycle valid strobe, holding the pipeline with `stall_o` until the response is ready. It sits beside the MEM stage and replaces the zero-latency data memory model with a cycle-accurate, wait-state-capable memory.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: byte-address width. The array holds 2**(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, 1: wait cycles inserted before each access. Legal range is 0..7.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `req_re_i`  in  1: load request.
- `req_we_i`  in  1: store request.
- `req_addr_i`  in  ADDR_WIDTH: byte address.
- `req_size_i`  in  data_size_e: access size. Legal values are BYTE_S, BYTE_U, HALF_S, HALF_U, WORD.
- `req_wdata_i`  in  32: store data, LSB-aligned (not lane-shifted).
- `stall_o`  out  1: MEM stage must hold its request and freeze the pipeline.
- `rsp_valid_o`  out  1: one-cycle response strobe.
- `rsp_rdata_o`  out  32: extended load data. Zero for stores and errors.
- `err_o`  out  1: request rejected. Valid with `rsp_valid_o`.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is present when `req_re_i | req_we_i`.
  - At the edge, the block captures addr, size, wdata and op.
  - It then goes to WAIT if WAIT_STATES>0, otherwise to RESP (access performed on this edge).
- WAIT:
  - A 3-bit counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - At count 0, the access is performed on the edge and the FSM goes to RESP.
- RESP: `rsp_valid_o`=1 for exactly one cycle, then the FSM returns to IDLE.
- Only captured values are used. Request inputs are ignored outside IDLE.
- Error conditions are checked in IDLE on the request cycle:
  - `req_re_i & req_we_i`.
  - Misalignment: HALF with addr[0]=1, or WORD with addr[1:0]≠0.
  - Undefined size.
- Error handling:
  - An erroring request still follows the normal WAIT/RESP sequence.
  - No array write occurs.
  - RESP shows `err_o`=1 and `rsp_rdata_o`=0.
- Word index is addr[ADDR_WIDTH-1:2]. Lane is addr[1:0].
- Stores:
  - Byte: lane k gets wdata[7:0].
  - Half: lanes {1,0} or {3,2} get wdata[15:0].
  - Word: all lanes.
  - Unwritten lanes are preserved.
  - Signed and unsigned size encodings behave identically for stores.
- Loads:
  - The block reads the full word and selects the lane.
  - BYTE_S/HALF_S sign-extend from bit 7/15. BYTE_U/HALF_U zero-extend. WORD passes through.
- `stall_o` = (state==IDLE & request present) | (state==WAIT). It is low in RESP, so the pipeline advances on the RESP edge and captures `rsp_rdata_o`.
- Array contents are not reset. Simulation initialises them to 0.

## Timing

- Request first visible in cycle 0 (IDLE). WAIT occupies cycles 1..W, where W=WAIT_STATES. RESP is cycle W+1.
- Occupancy per request is W+2 cycles. `stall_o` is high in cycles 0..W.
- Store commit happens on the edge ending cycle W (for W=0, the edge ending cycle 0).
- Load data is registered on the same edge and is valid during RESP.
- A back-to-back request may appear in the cycle after RESP.
- A store followed by a load to the same word returns the new data; there is no hazard because the commit precedes RESP.
- Reset values: state=IDLE, counter=0, `stall_o`=0 unless a request is present, `rsp_valid_o`=0, `rsp_rdata_o`=0, `err_o`=0.
- Reset mid-operation:
  - `rst` sampled high on any edge forces IDLE and has priority over commit.
  - A store whose commit edge coincides with `rst` is not written.
  - Reset discards any pending response; no `rsp_valid_o` follows.
- When IDLE with no request: `stall_o`=0 and outputs hold at 0.

## Test plan

- W=1. Store WORD 0xDEADBEEF @0x10, then load WORD @0x10 → `stall_o` high 2 cycles per request, `rsp_valid_o` in cycle 2, rdata=0xDEADBEEF.
- W=0. Store BYTE_U 0xAB @0x21 into word 0x11223344, then load BYTE_S @0x21 → word becomes 0x1122AB44, load returns 0xFFFFFFAB. Load BYTE_U @0x21 → 0x000000AB.
- W=3. Store HALF 0x8001 @0x32, then load HALF_S @0x32 → rdata 0xFFFF8001 at cycle 4. Load HALF_U → 0x00008001. Lanes 1:0 unchanged.
- Error cases:
  - Store WORD @0x41 → `err_o`=1 at RESP, rdata=0, memory unchanged.
  - `req_re_i`=`req_we_i`=1 → `err_o`=1.
- W=2. Assert `rst` on the commit edge of a store → word unchanged, no `rsp_valid_o`, outputs 0 the next cycle.
- Change `req_addr_i` and `req_wdata_i` during WAIT → captured values are used. Back-to-back requests sustain one response per W+2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one request at a time, configurable wait states,
// byte-lane stores and sign/zero-extended loads with a one-cycle response strobe.
package data_mem_pkg;
    typedef enum logic [2:0] {
        BYTE_S = 3'd0,
        HALF_S = 3'd1,
        WORD   = 3'd2,
        BYTE_U = 3'd4,
        HALF_U = 3'd5
    } data_size_e;
endpackage

module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_re_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  data_size_e            req_size_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  stall_o,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  err_o
);
    localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    data_size_e            size_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic                  err_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;

    logic                  req;
    logic                  req_err;
    logic                  in_idle;
    logic [ADDR_WIDTH-1:0] acc_addr;
    data_size_e            acc_size;
    logic [31:0]           acc_wdata;
    logic                  acc_we;
    logic                  acc_err;
    logic                  access;
    logic                  wr_en;
    logic                  is_byte;
    logic                  is_half;
    logic [3:0]            be;
    logic [ADDR_WIDTH-3:0] idx;
    logic [31:0]           rd_word;

    assign req     = req_re_i | req_we_i;
    assign in_idle = (state_q == S_IDLE);

    always_comb begin
        req_err = req_re_i & req_we_i;
        case (req_size_i)
            BYTE_S, BYTE_U: begin end
            HALF_S, HALF_U: if (req_addr_i[0]) req_err = 1'b1;
            WORD:           if (req_addr_i[1:0] != 2'b00) req_err = 1'b1;
            default:        req_err = 1'b1;
        endcase
    end

    // With zero wait states the access happens on the request edge, so use the live inputs.
    always_comb begin
        acc_addr  = addr_q;
        acc_size  = size_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        acc_err   = err_q;
        if (in_idle) begin
            acc_addr  = req_addr_i;
            acc_size  = req_size_i;
            acc_wdata = req_wdata_i;
            acc_we    = req_we_i;
            acc_err   = req_err;
        end
    end

    assign access  = (in_idle & req & NO_WAIT) | ((state_q == S_WAIT) & (cnt_q == 3'd0));
    assign wr_en   = access & acc_we & ~acc_err & ~rst;
    assign is_byte = (acc_size == BYTE_S) || (acc_size == BYTE_U);
    assign is_half = (acc_size == HALF_S) || (acc_size == HALF_U);
    assign idx     = acc_addr[ADDR_WIDTH-1:2];

    always_comb begin
        be = 4'b0000;
        if (is_byte)
            be = 4'b0001 << acc_addr[1:0];
        else if (is_half)
            be = acc_addr[1] ? 4'b1100 : 4'b0011;
        else if (acc_size == WORD)
            be = 4'b1111;
    end

    // One byte-wide RAM per lane so each lane write enable maps onto its own array.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rd_byte_q;
            logic [7:0] wbyte;

            always_comb begin
                wbyte = acc_wdata[8*gi +: 8];
                if (is_byte)
                    wbyte = acc_wdata[7:0];
                else if (is_half)
                    wbyte = acc_wdata[8*(gi%2) +: 8];
            end

            always_ff @(posedge clk) begin
                if (wr_en && be[gi])
                    mem_q[idx] <= wbyte;
                if (access)
                    rd_byte_q <= mem_q[idx];
            end

            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            size_q      <= WORD;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= req_addr_i;
                        size_q  <= req_size_i;
                        wdata_q <= req_wdata_i;
                        we_q    <= req_we_i;
                        err_q   <= req_err;
                        if (NO_WAIT) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [31:0] shifted;
    assign shifted = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        rsp_rdata_o = 32'd0;
        if (rsp_valid_q && !rsp_err_q && !we_q) begin
            case (size_q)
                BYTE_S:  rsp_rdata_o = {{24{shifted[7]}}, shifted[7:0]};
                BYTE_U:  rsp_rdata_o = {24'd0, shifted[7:0]};
                HALF_S:  rsp_rdata_o = {{16{shifted[15]}}, shifted[15:0]};
                HALF_U:  rsp_rdata_o = {16'd0, shifted[15:0]};
                default: rsp_rdata_o = rd_word;
            endcase
        end
    end

    assign stall_o     = (in_idle & req) | (state_q == S_WAIT);
    assign rsp_valid_o = rsp_valid_q;
    assign err_o       = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances with 0..3 wait states,
// table-driven request vectors plus hand sequences for reset and back-to-back timing.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_s    [NDUT];
    logic        we_s    [NDUT];
    logic [9:0]  addr_s  [NDUT];
    data_size_e  size_s  [NDUT];
    logic [31:0] wdata_s [NDUT];
    logic        stall_s [NDUT];
    logic        vld_s   [NDUT];
    logic        err_s   [NDUT];
    logic [31:0] rdata_s [NDUT];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            data_mem_responder #(
                .ADDR_WIDTH (10),
                .WAIT_STATES(gi)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_re_i   (re_s[gi]),
                .req_we_i   (we_s[gi]),
                .req_addr_i (addr_s[gi]),
                .req_size_i (size_s[gi]),
                .req_wdata_i(wdata_s[gi]),
                .stall_o    (stall_s[gi]),
                .rsp_valid_o(vld_s[gi]),
                .rsp_rdata_o(rdata_s[gi]),
                .err_o      (err_s[gi])
            );
        end
    endgenerate

    typedef struct {
        int          dut;
        logic        re;
        logic        we;
        logic [9:0]  addr;
        data_size_e  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int d, input logic r, input logic w, input logic [9:0] a,
                                input data_size_e s, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.dut = d; v.re = r; v.we = w; v.addr = a; v.size = s;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs(input int d);
        re_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = '0; size_s[d] = WORD; wdata_s[d] = '0;
    endtask

    // Drives one request starting just after an edge and walks it through W+2 cycles.
    task automatic do_req(input vec_t v, input string name);
        int          d;
        logic        ok;
        logic [31:0] rd;
        logic        e;
        d  = v.dut;
        ok = 1'b1;
        re_s[d] = v.re; we_s[d] = v.we; addr_s[d] = v.addr; size_s[d] = v.size; wdata_s[d] = v.wdata;
        for (int c = 0; c <= d; c++) begin
            @(negedge clk);
            if (stall_s[d] !== 1'b1 || vld_s[d] !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
            if (c < d) begin
                addr_s[d]  = 10'($urandom);
                wdata_s[d] = $urandom;
            end
        end
        @(negedge clk);
        if (vld_s[d] !== 1'b1 || stall_s[d] !== 1'b0) ok = 1'b0;
        rd = rdata_s[d];
        e  = err_s[d];
        idle_inputs(d);
        @(posedge clk); #1;
        if (vld_s[d] !== 1'b0 || stall_s[d] !== 1'b0 || err_s[d] !== 1'b0 || rdata_s[d] !== 32'd0)
            ok = 1'b0;
        check({name, " timing"}, 32'(ok), 32'd1);
        check({name, " rdata"}, rd, v.exp_rdata);
        check({name, " err"}, 32'(e), 32'(v.exp_err));
        $display("%s dut%0d re=%0b we=%0b addr=0x%03h size=%0d wdata=0x%08h -> rdata=0x%08h err=%0b",
                 name, d, v.re, v.we, v.addr, v.size, v.wdata, rd, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   t0;
        // W=1: word store/load and every lane extension
        tbl.push_back(mk(1, 0, 1, 10'h010, WORD,   32'hDEADBEEF, 32'h00000000, 0));
        tbl.push_back(mk(1, 1, 0, 10'h010, WORD,   32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 1, 0, 10'h013, BYTE_S, 32'h0,        32'hFFFFFFDE, 0));
        tbl.push_back(mk(1, 1, 0, 10'h011, BYTE_U, 32'h0,        32'h000000BE, 0));
        tbl.push_back(mk(1, 1, 0, 10'h012, HALF_U, 32'h0,        32'h0000DEAD, 0));
        tbl.push_back(mk(1, 1, 0, 10'h010, HALF_S, 32'h0,        32'hFFFFBEEF, 0));
        tbl.push_back(mk(1, 1, 0, 10'h010, BYTE_S, 32'h0,        32'hFFFFFFEF, 0));
        // W=0: byte stores preserve other lanes
        tbl.push_back(mk(0, 0, 1, 10'h020, WORD,   32'h11223344, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 10'h021, BYTE_U, 32'h123456AB, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 10'h020, WORD,   32'h0,        32'h1122AB44, 0));
        tbl.push_back(mk(0, 1, 0, 10'h021, BYTE_S, 32'h0,        32'hFFFFFFAB, 0));
        tbl.push_back(mk(0, 1, 0, 10'h021, BYTE_U, 32'h0,        32'h000000AB, 0));
        tbl.push_back(mk(0, 0, 1, 10'h023, BYTE_S, 32'hFFFFFF77, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 10'h020, WORD,   32'h0,        32'h7722AB44, 0));
        // W=3: half stores
        tbl.push_back(mk(3, 0, 1, 10'h030, WORD,   32'h55667788, 32'h0,        0));
        tbl.push_back(mk(3, 0, 1, 10'h032, HALF_U, 32'h12348001, 32'h0,        0));
        tbl.push_back(mk(3, 1, 0, 10'h032, HALF_S, 32'h0,        32'hFFFF8001, 0));
        tbl.push_back(mk(3, 1, 0, 10'h032, HALF_U, 32'h0,        32'h00008001, 0));
        tbl.push_back(mk(3, 1, 0, 10'h030, HALF_U, 32'h0,        32'h00007788, 0));
        tbl.push_back(mk(3, 0, 1, 10'h030, HALF_S, 32'hBEEF1234, 32'h0,        0));
        tbl.push_back(mk(3, 1, 0, 10'h030, WORD,   32'h0,        32'h80011234, 0));
        // W=1: error cases leave memory untouched and return zero data
        tbl.push_back(mk(1, 0, 1, 10'h040, WORD,   32'h00000000, 32'h0,        0));
        tbl.push_back(mk(1, 0, 1, 10'h041, WORD,   32'hCAFEF00D, 32'h0,        1));
        tbl.push_back(mk(1, 1, 0, 10'h040, WORD,   32'h0,        32'h00000000, 0));
        tbl.push_back(mk(1, 1, 1, 10'h040, WORD,   32'h12345678, 32'h0,        1));
        tbl.push_back(mk(1, 1, 0, 10'h040, WORD,   32'h0,        32'h00000000, 0));
        tbl.push_back(mk(1, 1, 0, 10'h011, HALF_S, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 1, 0, 10'h012, WORD,   32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 1, 0, 10'h010, data_size_e'(3'd3), 32'h0, 32'h0,   1));
        tbl.push_back(mk(1, 0, 1, 10'h043, HALF_U, 32'hFFFFFFFF, 32'h0,        1));
        tbl.push_back(mk(1, 1, 0, 10'h040, WORD,   32'h0,        32'h00000000, 0));
        // W=2: top word of the array, then the word used by the reset sequence
        tbl.push_back(mk(2, 0, 1, 10'h3FC, WORD,   32'h89ABCDEF, 32'h0,        0));
        tbl.push_back(mk(2, 1, 0, 10'h3FF, BYTE_S, 32'h0,        32'hFFFFFF89, 0));
        tbl.push_back(mk(2, 1, 0, 10'h3FE, BYTE_U, 32'h0,        32'h000000AB, 0));
        tbl.push_back(mk(2, 0, 1, 10'h050, WORD,   32'hA5A5A5A5, 32'h0,        0));

        for (int d = 0; d < NDUT; d++) idle_inputs(d);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset dut%0d outputs", d),
                  {29'd0, stall_s[d], vld_s[d], err_s[d]} | rdata_s[d], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) do_req(tbl[i], $sformatf("vec%0d", i));

        // Reset on the commit edge of a W=2 store: nothing written, no response.
        re_s[2] = 1'b0; we_s[2] = 1'b1; addr_s[2] = 10'h050; size_s[2] = WORD; wdata_s[2] = 32'h5A5A5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_store stall before reset", 32'(stall_s[2]), 32'd1);
        rst = 1'b1;
        idle_inputs(2);
        @(posedge clk); #1;
        check("rst_store outputs after reset",
              {29'd0, stall_s[2], vld_s[2], err_s[2]} | rdata_s[2], 32'd0);
        rst = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (vld_s[2] !== 1'b0) ok = 1'b0;
        end
        check("rst_store no late valid", 32'(ok), 32'd1);
        $display("rst_store dut2 reset on commit edge, valid suppressed=%0b", ok);
        do_req(mk(2, 1, 0, 10'h050, WORD, 32'h0, 32'hA5A5A5A5, 0), "rst_readback");

        // Back-to-back W=1 loads: one response every three cycles.
        t0 = cyc;
        do_req(mk(1, 1, 0, 10'h010, WORD, 32'h0, 32'hDEADBEEF, 0), "b2b0");
        do_req(mk(1, 1, 0, 10'h020, WORD, 32'h0, 32'h00000000, 0), "b2b1");
        do_req(mk(1, 1, 0, 10'h012, HALF_S, 32'h0, 32'hFFFFDEAD, 0), "b2b2");
        check("b2b cycles for three requests", 32'(cyc - t0), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
